// File: rtl/dual_rail_pkg.sv
// Shared types and helpers for the dual-rail Gray-walk monitor.
package dual_rail_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        TRACK,
        DONE,
        ERR
    } state_t;

    localparam int          NUM_VARS    = 4;
    localparam logic [15:0] ALL_VISITED = 16'hFFFF;

    function automatic logic [2:0] popcount4(input logic [NUM_VARS-1:0] x);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < NUM_VARS; i++) begin
            cnt = cnt + 3'(x[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/dr_stable_filter.sv
// Rail-pair validity check and skew filter: flags a stable candidate once it has been
// seen on STABLE_CYCLES consecutive edges, and a rail fault on a long invalid run.
module dr_stable_filter
    import dual_rail_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [NUM_VARS-1:0] rail,
    input  logic [NUM_VARS-1:0] rail_n,
    output logic                stable,
    output logic [NUM_VARS-1:0] cand,
    output logic                rail_fault
);

    localparam int            SW    = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] SC    = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] SC_M1 = SW'(STABLE_CYCLES - 1);

    logic [SW-1:0]       stab_cnt;
    logic [SW-1:0]       invl_cnt;
    logic [NUM_VARS-1:0] prev_p0;
    logic                samp_vld;
    logic                same;

    assign samp_vld = &(rail ^ rail_n);
    assign cand     = rail;
    // A non-zero stab_cnt implies the previous sample was valid.
    assign same     = (stab_cnt != '0) && (cand == prev_p0);

    // Both pulses fire on the edge where the respective counter reaches STABLE_CYCLES.
    assign stable     = samp_vld && same && (stab_cnt == SC_M1);
    assign rail_fault = !samp_vld && (invl_cnt == SC_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
            invl_cnt <= '0;
            prev_p0  <= '0;
        end else if (clr) begin
            stab_cnt <= '0;
            invl_cnt <= '0;
            prev_p0  <= '0;
        end else begin
            prev_p0 <= cand;
            if (samp_vld) begin
                invl_cnt <= '0;
                if (same) begin
                    stab_cnt <= (stab_cnt == SC) ? stab_cnt : stab_cnt + 1'b1;
                end else begin
                    stab_cnt <= SW'(1);
                end
            end else begin
                stab_cnt <= '0;
                invl_cnt <= (invl_cnt == SC) ? invl_cnt : invl_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dual_rail_gray_monitor.sv
// Receive-side monitor for the dual-rail stimulus bus of f1: Gray-walk enforcement,
// state coverage and per-code truth-table capture.
module dual_rail_gray_monitor
    import dual_rail_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             a2,
    input  logic             b,
    input  logic             b2,
    input  logic             c,
    input  logic             c2,
    input  logic             d,
    input  logic             d2,
    input  logic             f_in,
    output logic [3:0]       code,
    output logic             code_vld,
    output logic [CNT_W-1:0] step_cnt,
    output logic [15:0]      visited,
    output logic [15:0]      truth,
    output logic             rail_err,
    output logic             step_err,
    output logic             done
);

    state_t              state, nxt;
    logic                stable;
    logic                rail_fault;
    logic [NUM_VARS-1:0] cand;
    logic                accept;
    logic                single_step;

    logic [3:0]       code_n;
    logic             vld_n;
    logic [CNT_W-1:0] step_n;
    logic [15:0]      vis_n;
    logic [15:0]      truth_n;
    logic             rerr_n;
    logic             serr_n;
    logic             done_n;

    dr_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (~en),
        .rail      ({a, b, c, d}),
        .rail_n    ({a2, b2, c2, d2}),
        .stable    (stable),
        .cand      (cand),
        .rail_fault(rail_fault)
    );

    // The first accept of a walk is taken even if it matches the retained code.
    assign accept      = stable && ((state == FIRST) || (cand != code));
    assign single_step = (popcount4(cand ^ code) == 3'd1);

    always_comb begin
        nxt     = state;
        code_n  = code;
        vld_n   = 1'b0;
        step_n  = step_cnt;
        vis_n   = visited;
        truth_n = truth;
        rerr_n  = rail_err;
        serr_n  = step_err;
        done_n  = done;

        if (!en) begin
            nxt    = IDLE;
            step_n = '0;
            vis_n  = '0;
            rerr_n = 1'b0;
            serr_n = 1'b0;
            done_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    nxt     = FIRST;
                    truth_n = '0;
                end
                FIRST: begin
                    if (rail_fault) begin
                        rerr_n = 1'b1;
                        nxt    = ERR;
                    end else if (accept) begin
                        code_n        = cand;
                        vld_n         = 1'b1;
                        step_n        = '0;
                        vis_n         = visited | (16'd1 << cand);
                        truth_n[cand] = f_in;
                        nxt           = TRACK;
                    end
                end
                TRACK, DONE: begin
                    if (rail_fault) begin
                        rerr_n = 1'b1;
                        nxt    = ERR;
                    end else if (accept) begin
                        code_n = cand;
                        vld_n  = 1'b1;
                        if (single_step) begin
                            if (step_cnt != {CNT_W{1'b1}}) begin
                                step_n = step_cnt + 1'b1;
                            end
                            vis_n         = visited | (16'd1 << cand);
                            truth_n[cand] = f_in;
                            if ((state == TRACK) && (vis_n == ALL_VISITED)) begin
                                nxt    = DONE;
                                done_n = 1'b1;
                            end
                        end else begin
                            serr_n = 1'b1;
                            nxt    = ERR;
                        end
                    end
                end
                ERR: begin
                    vld_n = accept;
                end
                default: nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            code     <= '0;
            code_vld <= 1'b0;
            step_cnt <= '0;
            visited  <= '0;
            truth    <= '0;
            rail_err <= 1'b0;
            step_err <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= nxt;
            code     <= code_n;
            code_vld <= vld_n;
            step_cnt <= step_n;
            visited  <= vis_n;
            truth    <= truth_n;
            rail_err <= rerr_n;
            step_err <= serr_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_dual_rail_gray_monitor.sv
// Directed bench for dual_rail_gray_monitor: Gray walk, skew, rail/step errors, fast toggling, reset.
module tb_dual_rail_gray_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        a = 1'b0, a2 = 1'b1, b = 1'b0, b2 = 1'b1;
    logic        c = 1'b0, c2 = 1'b1, d = 1'b0, d2 = 1'b1;
    logic        f_in = 1'b0;
    logic [3:0]  code;
    logic        code_vld;
    logic [4:0]  step_cnt;
    logic [15:0] visited;
    logic [15:0] truth;
    logic        rail_err, step_err, done;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    logic [15:0] f1_tab = 16'hB5E2;
    logic [3:0]  walk [16] = '{4'h0, 4'h8, 4'hC, 4'h4, 4'h6, 4'hE, 4'hA, 4'h2,
                               4'h3, 4'hB, 4'hF, 4'h7, 4'h5, 4'hD, 4'h9, 4'h1};

    always #5 clk = ~clk;

    dual_rail_gray_monitor #(.STABLE_CYCLES(4), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .a(a), .a2(a2), .b(b), .b2(b2), .c(c), .c2(c2), .d(d), .d2(d2),
        .f_in(f_in), .code(code), .code_vld(code_vld), .step_cnt(step_cnt),
        .visited(visited), .truth(truth), .rail_err(rail_err),
        .step_err(step_err), .done(done)
    );

    task automatic drive_code(input logic [3:0] v);
        {a, b, c, d} = v;
        {a2, b2, c2, d2} = ~v;
        f_in = f1_tab[v];
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (code_vld) pulses++;
        end
    endtask

    task automatic restart(input logic [3:0] v);
        en = 1'b0;
        run_cycles(2);
        en = 1'b1;
        drive_code(v);
        run_cycles(6);
        pulses = 0;
    endtask

    task automatic test_reset();
        drive_code(4'h0);
        #12;
        total++;
        if ({code, code_vld, step_cnt, visited, truth, rail_err, step_err, done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got code=%h vld=%b step=%0d vis=%h truth=%h", code, code_vld, step_cnt, visited, truth);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(2);
    endtask

    task automatic test_walk();
        pulses = 0;
        en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_code(walk[i]);
            run_cycles(10);
        end
        total++;
        if (pulses != 16) begin bad++; $display("FAIL walk_pulses: got %0d want 16", pulses); end
        total++;
        if (step_cnt !== 5'd15) begin bad++; $display("FAIL walk_step_cnt: got %0d want 15", step_cnt); end
        total++;
        if (visited !== 16'hFFFF) begin bad++; $display("FAIL walk_visited: got %h want ffff", visited); end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL walk_done: got %b want 1", done); end
        total++;
        if (truth !== 16'hB5E2) begin bad++; $display("FAIL walk_truth: got %h want b5e2", truth); end
        total++;
        if ({rail_err, step_err} !== 2'b00) begin bad++; $display("FAIL walk_errs: got %b want 00", {rail_err, step_err}); end
        total++;
        if (code !== 4'h1) begin bad++; $display("FAIL walk_code: got %h want 1", code); end
    endtask

    task automatic test_skew();
        restart(4'h0);
        a = 1'b1;
        run_cycles(1);
        drive_code(4'h8);
        run_cycles(3);
        total++;
        if (code !== 4'h0) begin bad++; $display("FAIL skew_early: got %h want 0", code); end
        run_cycles(1);
        total++;
        if ({code_vld, code} !== 5'h18) begin bad++; $display("FAIL skew_accept: got vld=%b code=%h want 1/8", code_vld, code); end
        total++;
        if (rail_err !== 1'b0) begin bad++; $display("FAIL skew_rail_err: got %b want 0", rail_err); end
    endtask

    task automatic test_rail_err();
        restart(4'h0);
        a = 1'b1;
        run_cycles(3);
        total++;
        if (rail_err !== 1'b0) begin bad++; $display("FAIL rail_err_early: got %b want 0", rail_err); end
        run_cycles(1);
        total++;
        if (rail_err !== 1'b1) begin bad++; $display("FAIL rail_err_set: got %b want 1", rail_err); end
        pulses = 0;
        drive_code(4'h8);
        run_cycles(6);
        total++;
        if (code !== 4'h0) begin bad++; $display("FAIL rail_err_hold_code: got %h want 0", code); end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL rail_err_vld_pulse: got %0d want 1", pulses); end
        en = 1'b0;
        run_cycles(1);
        total++;
        if (rail_err !== 1'b0) begin bad++; $display("FAIL rail_err_clear: got %b want 0", rail_err); end
    endtask

    task automatic test_step_err();
        restart(4'h0);
        drive_code(4'hC);
        run_cycles(6);
        total++;
        if (step_err !== 1'b1) begin bad++; $display("FAIL step_err_set: got %b want 1", step_err); end
        total++;
        if (code !== 4'hC) begin bad++; $display("FAIL step_err_code: got %h want c", code); end
        total++;
        if (step_cnt !== 5'd0) begin bad++; $display("FAIL step_err_cnt: got %0d want 0", step_cnt); end
        total++;
        if (visited !== 16'h0001) begin bad++; $display("FAIL step_err_visited: got %h want 0001", visited); end
        drive_code(4'h8);
        run_cycles(6);
        total++;
        if (code !== 4'hC) begin bad++; $display("FAIL step_err_hold: got %h want c", code); end
    endtask

    task automatic test_fast_toggle();
        logic [3:0] seq [5] = '{4'h8, 4'hC, 4'h4, 4'hC, 4'h8};
        restart(4'h0);
        for (int i = 0; i < 5; i++) begin
            drive_code(seq[i]);
            run_cycles(3);
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL toggle_no_accept: got %0d pulses want 0", pulses); end
        total++;
        if (code !== 4'h0) begin bad++; $display("FAIL toggle_code: got %h want 0", code); end
        run_cycles(1);
        total++;
        if ({code_vld, code} !== 5'h18) begin bad++; $display("FAIL toggle_fourth: got vld=%b code=%h want 1/8", code_vld, code); end
    endtask

    task automatic test_async_reset();
        restart(4'h0);
        for (int i = 1; i < 8; i++) begin
            drive_code(walk[i]);
            run_cycles(6);
        end
        total++;
        if ({step_cnt, code} !== {5'd7, 4'h2}) begin bad++; $display("FAIL pre_reset: got step=%0d code=%h want 7/2", step_cnt, code); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({code, code_vld, step_cnt, visited, truth, rail_err, step_err, done} !== '0) begin
            bad++;
            $display("FAIL async_reset: got code=%h step=%0d vis=%h truth=%h", code, step_cnt, visited, truth);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(4);
        total++;
        if ({code_vld, code, step_cnt} !== {1'b1, 4'h2, 5'd0}) begin
            bad++;
            $display("FAIL restart_accept: got vld=%b code=%h step=%0d want 1/2/0", code_vld, code, step_cnt);
        end
        total++;
        if ({visited, truth} !== {16'h0004, 16'h0000}) begin
            bad++;
            $display("FAIL restart_tables: got vis=%h truth=%h want 0004/0000", visited, truth);
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_skew();
        test_rail_err();
        test_step_err();
        test_fast_toggle();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
